// File: rtl/pipeline_ctrl_if.sv
// Hazard-request / pipeline-strobe bundle for pipeline_ctrl.
// master: the requesting side (hazard detector, EX/MEM units, bench).
// slave:  the sequencer itself.
interface pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  // Hazard and resource requests
  logic             load_use_stall;
  logic             branch_taken;
  logic             muldiv_start;
  logic             imem_wait;
  logic             dmem_wait;

  // Pipeline register strobes
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             ex_mem_flush;
  logic             mem_wb_en;

  // MUL/DIV status
  logic             muldiv_busy;
  logic             muldiv_done;

  // Performance counters
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;

  modport master (
    output load_use_stall, branch_taken, muldiv_start, imem_wait, dmem_wait,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
    input  mem_wb_en, muldiv_busy, muldiv_done, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  load_use_stall, branch_taken, muldiv_start, imem_wait, dmem_wait,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
    output mem_wb_en, muldiv_busy, muldiv_done, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Merges hazard requests into per-register enable/flush strobes and owns the
// MUL/DIV occupancy FSM. Priority: dmem_wait > MUL/DIV > branch > load-use > imem_wait.
// Optional feature macro: PIPELINE_CTRL_PERF_EN enables the saturating stall/flush
// performance counters; when undefined both perf ports read 0.
module pipeline_ctrl #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.slave bus
);

  // Counter only has to hold MULDIV_LAT-2, the remaining stall cycles after entry.
  localparam int unsigned CntW    = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam int unsigned LoadVal = (MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0;
  localparam bit          SingleCycle = (MULDIV_LAT == 1);

  localparam logic [0:0] StRun    = 1'b0;
  localparam logic [0:0] StMuldiv = 1'b1;

  if (MULDIV_LAT < 1) begin : g_bad_lat
    $error("MULDIV_LAT must be at least 1");
  end

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic muldiv_active;
  logic muldiv_done;
  logic branch_accept;

  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, ex_mem_flush, mem_wb_en;

  // EX is owned by a MUL/DIV op while in MULDIV or on its first cycle in RUN.
  assign muldiv_active = (state_q == StMuldiv) || bus.muldiv_start;

  // Result latches into EX/MEM on the last unstalled EX cycle of the op.
  assign muldiv_done = rst_n && !bus.dmem_wait &&
                       (((state_q == StMuldiv) && (cnt_q == '0)) ||
                        ((state_q == StRun) && bus.muldiv_start && SingleCycle));

  // A branch is honoured only in RUN with no memory stall and no MUL/DIV in EX.
  assign branch_accept = rst_n && !bus.dmem_wait && !muldiv_active && bus.branch_taken;

  // Strobe generation: combinational so requests take effect in the same cycle.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;

    if (!rst_n) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (bus.dmem_wait) begin
      // Whole pipe freezes; nothing may be flushed while MEM is stuck.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (muldiv_active) begin
      if (!muldiv_done) begin
        // Hold the front end; EX/MEM takes bubbles until the result is ready.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_flush = 1'b1;
      end
    end else if (bus.branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (bus.load_use_stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (bus.imem_wait) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  // FSM next-state: counts down the MUL/DIV occupancy, frozen by dmem_wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!bus.dmem_wait) begin
      unique case (state_q)
        StRun: begin
          if (bus.muldiv_start && !SingleCycle) begin
            state_d = StMuldiv;
            cnt_d   = CntW'(LoadVal);
          end
        end
        StMuldiv: begin
          if (cnt_q == '0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM state register; async reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters: stall cycles (pc_en low) and accepted branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (branch_accept && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
  assign bus.perf_flush_cnt = flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf        = branch_accept;
  assign bus.perf_stall_cnt = {CNT_W{1'b0}};
  assign bus.perf_flush_cnt = {CNT_W{1'b0}};
`endif

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.muldiv_busy  = rst_n && (state_q == StMuldiv);
  assign bus.muldiv_done  = muldiv_done;

endmodule
